// File: rtl/led_bus_responder.sv
// Memory-mapped LED peripheral: static pattern plus hardware blink engine on the load/store bus.
// Latency: bus_ready in cycle N+1+WAIT_CYCLES after the request is sampled; led is registered (+1 cycle).
// Backpressure: requests are held by the master until bus_ready; one transfer in flight, WAIT_CYCLES+2 cycles each.
module led_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          LED_W       = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bus_valid,
    input  logic             i_bus_we,
    input  logic [31:0]      i_bus_addr,
    input  logic [31:0]      i_bus_wdata,
    input  logic [3:0]       i_bus_wstrb,
    output logic             o_bus_ready,
    output logic [31:0]      o_bus_rdata,
    output logic [LED_W-1:0] o_led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Word offsets within the 16-byte register window.
    localparam logic [1:0] OFF_LED = 2'd0;
    localparam logic [1:0] OFF_MSK = 2'd1;
    localparam logic [1:0] OFF_PER = 2'd2;
    localparam logic [1:0] OFF_CNT = 2'd3;

    // Last value of the wait counter before moving to RESP.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Bus FSM state and the latched request.
    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_wait_cnt;
    logic              r_we;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;

    // Register file and blink engine.
    logic [LED_W-1:0]  r_led_out;
    logic [LED_W-1:0]  r_blink_msk;
    logic [31:0]       r_blink_per;
    logic [31:0]       r_cnt;
    logic              r_phase;
    logic [LED_W-1:0]  r_led;

    // Request decode and effective request fields.
    logic              w_hit;
    logic              w_we;
    logic [1:0]        w_off;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic              w_enter_resp;
    logic              w_wr;
    logic              w_wr_led;
    logic              w_wr_msk;
    logic              w_wr_per;
    logic [31:0]       w_byte_mask;
    logic [LED_W-1:0]  w_led_out_nxt;
    logic [LED_W-1:0]  w_blink_msk_nxt;
    logic [31:0]       w_blink_per_nxt;
    logic [31:0]       w_rd_dat;
    logic              w_unused_addr;

    // The byte-offset bits carry no meaning for word registers.
    assign w_unused_addr = ^i_bus_addr[1:0];

    assign w_hit = i_bus_valid && (i_bus_addr[31:4] == BASE_ADDR[31:4]);

    // With zero wait states the store commits straight out of IDLE, before the
    // request has been latched, so the live bus fields are used in that state.
    assign w_we    = (r_state == S_IDLE) ? i_bus_we          : r_we;
    assign w_off   = (r_state == S_IDLE) ? i_bus_addr[3:2]   : r_off;
    assign w_wdata = (r_state == S_IDLE) ? i_bus_wdata       : r_wdata;
    assign w_wstrb = (r_state == S_IDLE) ? i_bus_wstrb       : r_wstrb;

    // Register side effects happen on the edge that enters RESP.
    assign w_enter_resp = (r_state != S_RESP) && (w_state_nxt == S_RESP);
    assign w_wr         = w_enter_resp && w_we;
    assign w_wr_led     = w_wr && (w_off == OFF_LED);
    assign w_wr_msk     = w_wr && (w_off == OFF_MSK);
    assign w_wr_per     = w_wr && (w_off == OFF_PER);

    assign w_byte_mask = {{8{w_wstrb[3]}}, {8{w_wstrb[2]}}, {8{w_wstrb[1]}}, {8{w_wstrb[0]}}};

    // Byte-lane merge of store data; lanes above LED_W simply fall off the narrow registers.
    always_comb begin
        w_led_out_nxt   = (r_led_out   & ~w_byte_mask[LED_W-1:0]) | (w_wdata[LED_W-1:0] & w_byte_mask[LED_W-1:0]);
        w_blink_msk_nxt = (r_blink_msk & ~w_byte_mask[LED_W-1:0]) | (w_wdata[LED_W-1:0] & w_byte_mask[LED_W-1:0]);
        w_blink_per_nxt = (r_blink_per & ~w_byte_mask) | (w_wdata & w_byte_mask);
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd_dat = '0;
        case (w_off)
            OFF_LED: w_rd_dat[LED_W-1:0] = r_led_out;
            OFF_MSK: w_rd_dat[LED_W-1:0] = r_blink_msk;
            OFF_PER: w_rd_dat            = r_blink_per;
            OFF_CNT: w_rd_dat            = r_cnt;
            default: w_rd_dat            = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: RESP always lasts one cycle and ignores bus_valid.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait-state counter runs only while in WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end

    // Latch the request when it is accepted in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_off   <= 2'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else if ((r_state == S_IDLE) && w_hit) begin
            r_we    <= i_bus_we;
            r_off   <= i_bus_addr[3:2];
            r_wdata <= i_bus_wdata;
            r_wstrb <= i_bus_wstrb;
        end
    end

    // Load data is captured on entry to RESP and forced to zero otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_enter_resp && !w_we) begin
            r_rdata <= w_rd_dat;
        end else begin
            r_rdata <= 32'd0;
        end
    end

    // Writable registers; BLINK_CNT is read-only and stores to it only get acknowledged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led_out   <= '0;
            r_blink_msk <= '0;
            r_blink_per <= 32'd0;
        end else begin
            if (w_wr_led) begin
                r_led_out <= w_led_out_nxt;
            end
            if (w_wr_msk) begin
                r_blink_msk <= w_blink_msk_nxt;
            end
            if (w_wr_per) begin
                r_blink_per <= w_blink_per_nxt;
            end
        end
    end

    // Blink engine: a store to BLINK_PER restarts the phase and wins over a same-edge wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (w_wr_per) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (r_blink_per == 32'd0) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (r_cnt == (r_blink_per - 32'd1)) begin
            r_cnt   <= 32'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Registered LED drive: static pattern with masked LEDs inverted in the odd phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= r_led_out ^ (r_blink_msk & {LED_W{r_phase}});
        end
    end

    assign o_bus_ready = (r_state == S_RESP);
    assign o_bus_rdata = r_rdata;
    assign o_led       = r_led;

endmodule

// File: tb/tb_led_bus_responder.sv
// Directed bench for led_bus_responder: bus protocol, register map, blink engine and reset.
// Latency: expects bus_ready two cycles after the request is sampled (one wait state).
// Backpressure: master holds bus_valid until bus_ready; one idle cycle between transfers.
module tb_led_bus_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_bus_valid;
    logic        i_bus_we;
    logic [31:0] i_bus_addr;
    logic [31:0] i_bus_wdata;
    logic [3:0]  i_bus_wstrb;
    logic        o_bus_ready;
    logic [31:0] o_bus_rdata;
    logic [7:0]  o_led;

    int n_pass  = 0;
    int n_total = 0;

    led_bus_responder #(
        .BASE_ADDR  (BASE),
        .LED_W      (8),
        .WAIT_CYCLES(1)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_bus_valid(i_bus_valid),
        .i_bus_we   (i_bus_we),
        .i_bus_addr (i_bus_addr),
        .i_bus_wdata(i_bus_wdata),
        .i_bus_wstrb(i_bus_wstrb),
        .o_bus_ready(o_bus_ready),
        .o_bus_rdata(o_bus_rdata),
        .o_led      (o_led)
    );

    always #5 i_clk = ~i_clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One bus transfer; returns load data and the number of edges from request to bus_ready
    // (20 on timeout), then leaves one idle cycle.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output int lat);
        logic done;
        i_bus_valid = 1'b1;
        i_bus_we    = we;
        i_bus_addr  = addr;
        i_bus_wdata = wdata;
        i_bus_wstrb = strb;
        rdata = 32'hDEAD_BEEF;
        lat   = 0;
        done  = 1'b0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (o_bus_ready) begin
                rdata = o_bus_rdata;
                done  = 1'b1;
            end
        end
        i_bus_valid = 1'b0;
        i_bus_we    = 1'b0;
        i_bus_wstrb = 4'd0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          nrdy;
        logic [7:0]  exp_led;

        i_rst_n     = 1'b0;
        i_bus_valid = 1'b0;
        i_bus_we    = 1'b0;
        i_bus_addr  = 32'd0;
        i_bus_wdata = 32'd0;
        i_bus_wstrb = 4'd0;

        // Reset state.
        repeat (3) tick();
        chk("rst_ready", 32'(o_bus_ready), 32'd0);
        chk("rst_rdata", o_bus_rdata, 32'd0);
        chk("rst_led", 32'(o_led), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Reset asserted mid-WAIT of a store of 0xA5 to LED_OUT drops the store.
        i_bus_valid = 1'b1;
        i_bus_we    = 1'b1;
        i_bus_addr  = BASE;
        i_bus_wdata = 32'h0000_00A5;
        i_bus_wstrb = 4'b1111;
        tick();
        chk("wait_ready", 32'(o_bus_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_bus_ready), 32'd0);
        chk("midrst_led", 32'(o_led), 32'd0);
        i_bus_valid = 1'b0;
        i_bus_we    = 1'b0;
        tick();
        chk("midrst_ready2", 32'(o_bus_ready), 32'd0);
        i_rst_n = 1'b1;
        tick();
        chk("midrst_led2", 32'(o_led), 32'd0);
        xfer(1'b0, BASE, 32'd0, 4'd0, rd, lat);
        chk("midrst_readback", rd, 32'd0);
        chk("midrst_lat", 32'(lat), 32'd2);

        // Store 0x3C with one byte lane, check latency, LED and readback.
        xfer(1'b1, BASE, 32'h0000_003C, 4'b0001, rd, lat);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_led", 32'(o_led), 32'h3C);
        xfer(1'b0, BASE + 32'h2, 32'd0, 4'd0, rd, lat);
        chk("ld_led_out", rd, 32'h0000_003C);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("idle_rdata", o_bus_rdata, 32'd0);
        chk("idle_ready", 32'(o_bus_ready), 32'd0);

        // Empty strobe and out-of-range lanes leave LED_OUT alone; stores to BLINK_CNT are ignored.
        xfer(1'b1, BASE, 32'h0000_00FF, 4'b0000, rd, lat);
        chk("nostrb_lat", 32'(lat), 32'd2);
        xfer(1'b1, BASE, 32'h1234_56FF, 4'b1110, rd, lat);
        chk("hilane_lat", 32'(lat), 32'd2);
        xfer(1'b0, BASE, 32'd0, 4'd0, rd, lat);
        chk("nostrb_readback", rd, 32'h0000_003C);
        chk("nostrb_led", 32'(o_led), 32'h3C);
        xfer(1'b1, BASE + 32'hC, 32'h0000_0055, 4'b1111, rd, lat);
        chk("cnt_st_lat", 32'(lat), 32'd2);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'd0, rd, lat);
        chk("cnt_readback", rd, 32'd0);

        // A miss is never acknowledged.
        i_bus_valid = 1'b1;
        i_bus_we    = 1'b0;
        i_bus_addr  = BASE + 32'h20;
        nrdy = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_bus_ready) nrdy++;
        end
        i_bus_valid = 1'b0;
        tick();
        chk("miss_ready_count", 32'(nrdy), 32'd0);

        // Blink at half-period 4: led alternates 0x0F / 0xF0.
        xfer(1'b1, BASE, 32'h0000_000F, 4'b0001, rd, lat);
        xfer(1'b1, BASE + 32'h4, 32'h0000_00FF, 4'b0001, rd, lat);
        chk("static_led", 32'(o_led), 32'h0F);
        xfer(1'b1, BASE + 32'h8, 32'd4, 4'b1111, rd, lat);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_led = (((k / 4) % 2) == 1) ? 8'hF0 : 8'h0F;
            chk($sformatf("blink4_k%0d", k), 32'(o_led), 32'(exp_led));
        end
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'd0, rd, lat);
        chk("blink4_cnt_range", 32'(rd < 32'd4), 32'd1);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'd0, rd, lat);
        chk("blink4_per_readback", rd, 32'd4);

        // Restart at period 4, then store period 2 so that it commits on a wrap edge.
        xfer(1'b1, BASE + 32'h8, 32'd4, 4'b1111, rd, lat);
        tick();
        xfer(1'b1, BASE + 32'h8, 32'd2, 4'b0001, rd, lat);
        chk("wrap_store_led", 32'(o_led), 32'h0F);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_led = (((k / 2) % 2) == 1) ? 8'hF0 : 8'h0F;
            chk($sformatf("blink2_k%0d", k), 32'(o_led), 32'(exp_led));
        end
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'd0, rd, lat);
        chk("blink2_cnt", rd, 32'd0);

        // bus_valid held for 10 loads of BLINK_MSK: one response every 3 cycles.
        i_bus_valid = 1'b1;
        i_bus_we    = 1'b0;
        i_bus_addr  = BASE + 32'h4;
        nrdy = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_bus_ready) begin
                chk($sformatf("b2b_cycle_%0d", nrdy), 32'(c), 32'(2 + 3 * nrdy));
                chk($sformatf("b2b_rdata_%0d", nrdy), o_bus_rdata, 32'h0000_00FF);
                nrdy++;
                if (nrdy == 10) i_bus_valid = 1'b0;
            end
        end
        chk("b2b_count", 32'(nrdy), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
